// File: rtl/evu_counter_bank_pkg.sv
// Shared types and constants for the event counter bank: CTRL layout, event indices, register map.
// Optional feature macro used by the bank: EVU_OVF_IRQ_EN (overflow interrupt).
package evu_counter_bank_pkg;

  localparam int unsigned EVU_SEL_W = 4;

  localparam logic EVU_REG_COUNT = 1'b0;
  localparam logic EVU_REG_CTRL  = 1'b1;

  localparam int unsigned EVU_CTRL_EN_BIT     = 0;
  localparam int unsigned EVU_CTRL_EDGE_BIT   = 1;
  localparam int unsigned EVU_CTRL_OVF_BIT    = 2;
  localparam int unsigned EVU_CTRL_IRQ_EN_BIT = 3;
  localparam int unsigned EVU_CTRL_SEL_LSB    = 8;

  typedef struct packed {
    logic [EVU_SEL_W-1:0] sel;
    logic                 irq_en;
    logic                 ovf;
    logic                 edge_mode;
    logic                 en;
  } evu_ctrl_t;

  typedef enum logic [EVU_SEL_W-1:0] {
    EVU_EV_CYCLE       = 4'd0,
    EVU_EV_ICACHE_MISS = 4'd1,
    EVU_EV_DCACHE_MISS = 4'd2,
    EVU_EV_ITLB_MISS   = 4'd3,
    EVU_EV_DTLB_MISS   = 4'd4,
    EVU_EV_LOAD        = 4'd5,
    EVU_EV_STORE       = 4'd6,
    EVU_EV_EXCEPTION   = 4'd7,
    EVU_EV_ERET        = 4'd8,
    EVU_EV_BRANCH      = 4'd9,
    EVU_EV_CALL        = 4'd10,
    EVU_EV_RET         = 4'd11,
    EVU_EV_MISPREDICT  = 4'd12,
    EVU_EV_SB_FULL     = 4'd13,
    EVU_EV_IF_EMPTY    = 4'd14
  } evu_event_e;

  // Software-visible CTRL image; unimplemented bits read as zero.
  function automatic logic [15:0] evu_ctrl_pack(input evu_ctrl_t c);
    logic [15:0] w;
    w = '0;
    w[EVU_CTRL_EN_BIT]                      = c.en;
    w[EVU_CTRL_EDGE_BIT]                    = c.edge_mode;
    w[EVU_CTRL_OVF_BIT]                     = c.ovf;
    w[EVU_CTRL_IRQ_EN_BIT]                  = c.irq_en;
    w[EVU_CTRL_SEL_LSB +: EVU_SEL_W]        = c.sel;
    return w;
  endfunction

endpackage

// File: rtl/evu_counter_bank_channel.sv
// One event counter channel: CTRL register, event select, edge detect, counter and sticky overflow.
// IRQ_EN bit is only stored when EVU_OVF_IRQ_EN is defined.
module evu_counter_bank_channel
  import evu_counter_bank_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 16,
  parameter int unsigned CNT_W      = 64,
  parameter int unsigned INC_W      = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_EVENTS*INC_W-1:0] ev_inc,
  input  logic                        halt,
  input  logic                        cnt_we,
  input  logic                        ctrl_we,
  input  logic [CNT_W-1:0]            wdata,
  output logic [CNT_W-1:0]            count,
  output evu_ctrl_t                   ctrl
);

  evu_ctrl_t        ctrl_q, ctrl_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             prev_nz_q;
  logic [INC_W-1:0] ev_val;
  logic [INC_W-1:0] inc;
  logic [CNT_W:0]   sum;

  // Event 0 is the free-running cycle event; its input slice is never used.
  always_comb begin
    ev_val = '0;
    for (int e = 0; e < NUM_EVENTS; e++) begin
      if (ctrl_q.sel == EVU_SEL_W'(e)) ev_val = ev_inc[e*INC_W +: INC_W];
    end
    if (ctrl_q.sel == '0) ev_val = INC_W'(1);
  end

  always_comb begin
    inc = '0;
    if (ctrl_q.en && !halt) begin
      if (ctrl_q.edge_mode) inc = ((ev_val != '0) && !prev_nz_q) ? INC_W'(1) : '0;
      else                  inc = ev_val;
    end
    sum = {1'b0, count_q} + {{(CNT_W+1-INC_W){1'b0}}, inc};
  end

  // A COUNT write overrides the increment and suppresses that cycle's carry;
  // a carry beats a same-cycle write-1-to-clear of OVF.
  always_comb begin
    ctrl_d  = ctrl_q;
    count_d = cnt_we ? wdata : sum[CNT_W-1:0];
    if (ctrl_we) begin
      ctrl_d.en        = wdata[EVU_CTRL_EN_BIT];
      ctrl_d.edge_mode = wdata[EVU_CTRL_EDGE_BIT];
      ctrl_d.sel       = wdata[EVU_CTRL_SEL_LSB +: EVU_SEL_W];
`ifdef EVU_OVF_IRQ_EN
      ctrl_d.irq_en    = wdata[EVU_CTRL_IRQ_EN_BIT];
`else
      ctrl_d.irq_en    = 1'b0;
`endif
      if (wdata[EVU_CTRL_OVF_BIT]) ctrl_d.ovf = 1'b0;
    end
    if (!cnt_we && sum[CNT_W]) ctrl_d.ovf = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q    <= '0;
      count_q   <= '0;
      prev_nz_q <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      prev_nz_q <= ctrl_we ? 1'b0 : (ev_val != '0);
    end
  end

  assign count = count_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/evu_counter_bank.sv
// Bank of NUM_CNT event counters with a request/grant/rvalid config port.
// Define EVU_OVF_IRQ_EN to enable the registered overflow interrupt on irq_o.
module evu_counter_bank
  import evu_counter_bank_pkg::*;
#(
  parameter int unsigned NUM_EVENTS = 16,
  parameter int unsigned NUM_CNT    = 4,
  parameter int unsigned CNT_W      = 64,
  parameter int unsigned INC_W      = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_EVENTS*INC_W-1:0]  ev_inc_i,
  input  logic                         halt_i,
  input  logic                         cfg_req_i,
  input  logic                         cfg_we_i,
  input  logic [$clog2(NUM_CNT):0]     cfg_addr_i,
  input  logic [CNT_W-1:0]             cfg_wdata_i,
  output logic                         cfg_gnt_o,
  output logic                         cfg_rvalid_o,
  output logic [CNT_W-1:0]             cfg_rdata_o,
  output logic [NUM_CNT-1:0]           ovf_o,
  output logic                         irq_o
);

  // Handshake: every request is granted in the same cycle; a granted read
  // returns cfg_rdata_o with a single-cycle cfg_rvalid_o pulse on the next cycle.
  localparam int unsigned CH_W = $clog2(NUM_CNT);

  logic [CH_W:0]    ch_sel;
  logic             reg_sel;
  logic             wr, rd;
  logic [CNT_W-1:0] rd_mux;
  logic             rvalid_q;
  logic [CNT_W-1:0] rdata_q;

  evu_ctrl_t        ctrl  [NUM_CNT];
  logic [CNT_W-1:0] count [NUM_CNT];

  assign ch_sel    = {1'b0, cfg_addr_i[CH_W:1]};
  assign reg_sel   = cfg_addr_i[0];
  assign cfg_gnt_o = cfg_req_i;
  assign wr        = cfg_req_i & cfg_we_i;
  assign rd        = cfg_req_i & ~cfg_we_i;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
    logic hit;
    assign hit = wr && (ch_sel == (CH_W+1)'(i));

    evu_counter_bank_channel #(
      .NUM_EVENTS (NUM_EVENTS),
      .CNT_W      (CNT_W),
      .INC_W      (INC_W)
    ) u_channel (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .ev_inc  (ev_inc_i),
      .halt    (halt_i),
      .cnt_we  (hit && (reg_sel == EVU_REG_COUNT)),
      .ctrl_we (hit && (reg_sel == EVU_REG_CTRL)),
      .wdata   (cfg_wdata_i),
      .count   (count[i]),
      .ctrl    (ctrl[i])
    );

    assign ovf_o[i] = ctrl[i].ovf;
  end

  // Out-of-range channel indices match no channel and read back as zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (ch_sel == (CH_W+1)'(i)) begin
        rd_mux = (reg_sel == EVU_REG_CTRL) ? CNT_W'(evu_ctrl_pack(ctrl[i])) : count[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd;
      if (rd) rdata_q <= rd_mux;
    end
  end

  assign cfg_rvalid_o = rvalid_q;
  assign cfg_rdata_o  = rdata_q;

`ifdef EVU_OVF_IRQ_EN
  logic irq_q;
  logic irq_d;

  always_comb begin
    irq_d = 1'b0;
    for (int i = 0; i < NUM_CNT; i++) irq_d = irq_d | (ctrl[i].ovf & ctrl[i].irq_en);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule
